// File: rtl/dac_serial_tx_pkg.sv
// Shared equaliser definitions used by the DAC transmit path.
//   DECIM / MAGN / N  : default input sample format (Q8.14, 23 bits with sign)
//   DAC_FRAME_BITS    : length of one serial DAC frame
//   DAC_CTRL          : control nibble sent ahead of the DAC code
//   state_t           : transmit FSM states
package dac_serial_tx_pkg;

    localparam int DECIM          = 14;
    localparam int MAGN           = 8;
    localparam int N              = DECIM + MAGN + 1;
    localparam int DAC_FRAME_BITS = 16;
    localparam logic [3:0] DAC_CTRL = 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/dac_serial_tx_q_to_dac_code.sv
// Combinational conversion of a signed Q(magn).(decim) sample to an
// offset-binary DAC code. The sample is clamped to [-1.0, +1.0 - 1 LSB],
// offset by +1.0 and truncated to the top DAC_BITS bits.
// Ports:
//   x       : signed input sample, N bits
//   code    : offset-binary DAC code, DAC_BITS bits
//   clipped : high when x lay outside the clamp range
module q_to_dac_code #(
    parameter int decim    = 14,
    parameter int N        = 23,
    parameter int DAC_BITS = 12
) (
    input  logic signed [N-1:0]        x,
    output logic        [DAC_BITS-1:0] code,
    output logic                       clipped
);

    localparam logic signed [N-1:0] MAX_V = N'((2 ** decim) - 1);
    localparam logic signed [N-1:0] MIN_V = -N'(2 ** decim);

    logic              clip_hi;
    logic              clip_lo;
    logic [decim:0]    u;
    logic              unused_lsbs;

    assign clip_hi = (x > MAX_V);
    assign clip_lo = (x < MIN_V);
    assign clipped = clip_hi | clip_lo;

    // Inside the clamp range the low decim+1 bits are the two's complement
    // value; adding 2^decim to it is just an inversion of its sign bit.
    always_comb begin
        if (clip_hi) begin
            u = '1;
        end else if (clip_lo) begin
            u = '0;
        end else begin
            u = {~x[decim], x[decim-1:0]};
        end
    end

    assign code        = u[decim -: DAC_BITS];
    assign unused_lsbs = ^u;

endmodule

// File: rtl/dac_serial_tx.sv
// Serial DAC transmitter at the output of the equaliser chain.
// Each accepted sample is converted to a 12-bit offset-binary code and sent
// as a 16-bit frame {DAC_CTRL, code}, MSB first, on sync_n/sclk/sdata.
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous active-high reset
//   gen_enable : one-cycle sample strobe, DataIn valid in the same cycle
//   DataIn     : signed Q(magn).(decim) sample
//   sync_n     : frame select, low for the 16 bit periods
//   sclk       : serial clock, idles high, DAC samples on falling edge
//   sdata      : serial data, changes on sclk rising
//   busy       : high while a frame (shift + gap) is in progress
//   sat_flag   : one-cycle pulse when the accepted sample was clipped
//   overrun    : one-cycle pulse when a strobe was dropped while busy
module dac_serial_tx
    import dac_serial_tx_pkg::*;
#(
    parameter int decim    = DECIM,
    parameter int magn     = MAGN,
    parameter int N        = decim + magn + 1,
    parameter int DAC_BITS = 12,
    parameter int CLK_DIV  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                gen_enable,
    input  logic signed [N-1:0] DataIn,
    output logic                sync_n,
    output logic                sclk,
    output logic                sdata,
    output logic                busy,
    output logic                sat_flag,
    output logic                overrun
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [3:0]    BIT_FIRST = 4'(DAC_FRAME_BITS - 1);

    logic [DAC_BITS-1:0]       code;
    logic                      clipped;
    logic [DAC_FRAME_BITS-1:0] new_frame;

    state_t                    state_q, state_d;
    logic [DAC_FRAME_BITS-1:0] frame_q, frame_d;
    logic [3:0]                bit_q, bit_d;
    logic [DW-1:0]             div_q, div_d;
    logic                      sync_n_q, sync_n_d;
    logic                      sclk_q, sclk_d;
    logic                      sdata_q, sdata_d;
    logic                      sat_q, sat_d;
    logic                      ovr_q, ovr_d;

    q_to_dac_code #(
        .decim    (decim),
        .N        (N),
        .DAC_BITS (DAC_BITS)
    ) u_conv (
        .x       (DataIn),
        .code    (code),
        .clipped (clipped)
    );

    always_comb begin
        new_frame = '0;
        new_frame[DAC_FRAME_BITS-1 -: 4] = DAC_CTRL;
        new_frame[DAC_BITS-1:0]          = code;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            sync_n_q <= 1'b1;
            sclk_q   <= 1'b1;
            sdata_q  <= 1'b0;
            sat_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            sync_n_q <= sync_n_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
            sat_q    <= sat_d;
            ovr_q    <= ovr_d;
        end
    end

    // Every output is a register; the next-value logic below sets up the
    // line levels one cycle ahead so the first SHIFT cycle already shows
    // sync_n low, sclk high and the frame MSB.
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        bit_d    = bit_q;
        div_d    = div_q;
        sync_n_d = sync_n_q;
        sclk_d   = sclk_q;
        sdata_d  = sdata_q;
        sat_d    = 1'b0;
        ovr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                sync_n_d = 1'b1;
                sclk_d   = 1'b1;
                sdata_d  = 1'b0;
                if (gen_enable) begin
                    state_d  = SHIFT;
                    frame_d  = new_frame;
                    bit_d    = BIT_FIRST;
                    div_d    = '0;
                    sync_n_d = 1'b0;
                    sdata_d  = new_frame[DAC_FRAME_BITS-1];
                    sat_d    = clipped;
                end
            end

            SHIFT: begin
                ovr_d = gen_enable;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == 4'd0) begin
                        state_d  = GAP;
                        sync_n_d = 1'b1;
                        sclk_d   = 1'b1;
                        sdata_d  = 1'b0;
                    end else begin
                        // Next bit is presented together with sclk rising.
                        bit_d   = bit_q - 4'd1;
                        sclk_d  = 1'b1;
                        sdata_d = frame_q[bit_q - 4'd1];
                    end
                end else begin
                    div_d = DW'(div_q + 1'b1);
                end
            end

            GAP: begin
                ovr_d = gen_enable;
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = DW'(div_q + 1'b1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sync_n   = sync_n_q;
    assign sclk     = sclk_q;
    assign sdata    = sdata_q;
    assign busy     = (state_q != IDLE);
    assign sat_flag = sat_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx at default parameters (CLK_DIV=4,
// 132-cycle frames). Outputs are sampled on the falling system clock edge.
module tb_dac_serial_tx;

    logic               clock;
    logic               reset;
    logic               gen_enable;
    logic signed [22:0] DataIn;
    logic               sync_n;
    logic               sclk;
    logic               sdata;
    logic               busy;
    logic               sat_flag;
    logic               overrun;

    int tests;
    int fails;

    dac_serial_tx dut (
        .clock      (clock),
        .reset      (reset),
        .gen_enable (gen_enable),
        .DataIn     (DataIn),
        .sync_n     (sync_n),
        .sclk       (sclk),
        .sdata      (sdata),
        .busy       (busy),
        .sat_flag   (sat_flag),
        .overrun    (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe one sample at the current falling edge, then observe frame
    // cycles 1..133 (cycle 133 is the first IDLE cycle). Extra strobes are
    // driven during cycles inj_a / inj_b (0 = none). Returns at the falling
    // edge of cycle 133 so a caller can strobe on the first IDLE cycle.
    task automatic run_frame(input logic [22:0] data, input int inj_a, input int inj_b,
                             output logic [15:0] frm, output int nbits, output int sync_cnt,
                             output int busy_cnt, output int sat_cnt, output int ovr_cnt);
        logic prev;
        frm = '0; nbits = 0; sync_cnt = 0; busy_cnt = 0; sat_cnt = 0; ovr_cnt = 0;
        gen_enable = 1'b1;
        DataIn     = data;
        @(negedge clock);
        gen_enable = 1'b0;
        DataIn     = 23'h155555;
        prev       = 1'b1;
        for (int c = 1; c <= 133; c++) begin
            if (!sync_n)  sync_cnt++;
            if (busy)     busy_cnt++;
            if (sat_flag) sat_cnt++;
            if (overrun)  ovr_cnt++;
            if (prev && !sclk) begin
                frm = {frm[14:0], sdata};
                nbits++;
            end
            prev = sclk;
            if (c < 133) begin
                if (c == inj_a || c == inj_b) begin
                    gen_enable = 1'b1;
                    DataIn     = 23'h008000;
                end
                @(negedge clock);
                gen_enable = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; gen_enable = 1'b0; DataIn = '0;
        repeat (3) @(negedge clock);
        tests++;
        if ({sync_n, sclk, sdata, busy, sat_flag, overrun} !== 6'b110000) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 110000",
                     {sync_n, sclk, sdata, busy, sat_flag, overrun});
        end
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if ({sync_n, sclk, sdata, busy} !== 4'b1100) begin
            fails++;
            $display("FAIL idle_after_reset: got %b want 1100", {sync_n, sclk, sdata, busy});
        end
    endtask

    task automatic test_conversion;
        logic [22:0] din [6];
        logic [15:0] exp_frm [6];
        int          exp_sat [6];
        logic [15:0] frm;
        int nbits, sc, bc, satc, ovc;
        din = '{23'h000000, 23'h002000, 23'h008000, 23'h7F4000, 23'h7FC000, 23'h003FFF};
        exp_frm = '{16'h0800, 16'h0C00, 16'h0FFF, 16'h0000, 16'h0000, 16'h0FFF};
        exp_sat = '{0, 0, 1, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            run_frame(din[i], 0, 0, frm, nbits, sc, bc, satc, ovc);
            tests++;
            if (frm !== exp_frm[i] || nbits != 16) begin
                fails++;
                $display("FAIL frame_%0d: got %h (%0d bits) want %h (16 bits)",
                         i, frm, nbits, exp_frm[i]);
            end
            tests++;
            if (sc != 128 || bc != 132) begin
                fails++;
                $display("FAIL timing_%0d: sync_low %0d busy %0d want 128 132", i, sc, bc);
            end
            tests++;
            if (satc != exp_sat[i] || ovc != 0) begin
                fails++;
                $display("FAIL flags_%0d: sat %0d ovr %0d want %0d 0", i, satc, ovc, exp_sat[i]);
            end
            repeat (3) @(negedge clock);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] frm;
        int nbits, sc, bc, satc, ovc;
        // Strobes at cycle 50 and at the last GAP cycle (132) are dropped.
        run_frame(23'h002000, 50, 132, frm, nbits, sc, bc, satc, ovc);
        tests++;
        if (frm !== 16'h0C00 || nbits != 16) begin
            fails++;
            $display("FAIL b2b_frame: got %h (%0d bits) want 0c00 (16 bits)", frm, nbits);
        end
        tests++;
        if (ovc != 2 || satc != 0) begin
            fails++;
            $display("FAIL b2b_flags: ovr %0d sat %0d want 2 0", ovc, satc);
        end
        tests++;
        if (bc != 132) begin
            fails++;
            $display("FAIL b2b_busy: got %0d want 132", bc);
        end
        // Strobe on the very first IDLE cycle must be accepted (+0.25 -> 0xA00).
        run_frame(23'h001000, 0, 0, frm, nbits, sc, bc, satc, ovc);
        tests++;
        if (frm !== 16'h0A00 || bc != 132 || sc != 128 || ovc != 0) begin
            fails++;
            $display("FAIL b2b_accept: frame %h busy %0d sync %0d ovr %0d want 0a00 132 128 0",
                     frm, bc, sc, ovc);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset_midframe;
        logic [15:0] frm;
        int nbits, sc, bc, satc, ovc;
        gen_enable = 1'b1;
        DataIn     = 23'h008000;
        @(negedge clock);
        gen_enable = 1'b0;
        repeat (69) @(negedge clock);
        tests++;
        if (busy !== 1'b1 || sync_n !== 1'b0) begin
            fails++;
            $display("FAIL mid_busy: busy %b sync_n %b want 1 0", busy, sync_n);
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({sync_n, sclk, sdata, busy} !== 4'b1100) begin
            fails++;
            $display("FAIL async_reset: got %b want 1100", {sync_n, sclk, sdata, busy});
        end
        @(negedge clock);
        reset = 1'b0;
        run_frame(23'h002000, 0, 0, frm, nbits, sc, bc, satc, ovc);
        tests++;
        if (frm !== 16'h0C00 || nbits != 16 || bc != 132 || sc != 128) begin
            fails++;
            $display("FAIL post_reset_frame: frame %h bits %0d busy %0d sync %0d want 0c00 16 132 128",
                     frm, nbits, bc, sc);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_conversion();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
